// File: rtl/regfile_pkg.sv
// Shared register-file constants and the saturating drop-counter helper used
// by the writeback arbiter.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam int unsigned DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] count);
        return (count == DROP_MAX) ? count : count + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches ptr, ptr+1, ... (mod NUM_REQ) for the first request,
// producing a one-hot grant and the matching binary index.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [IDX_W-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port among NUM_REQ writeback sources with a registered
// output stage. Optional write-bypass compare enabled by macro WB_BYPASS_EN.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = REG_DATA_W,
    parameter int unsigned ADDR_W  = REG_ADDR_W
) (
    input  logic                      clock,
    input  logic                      ctrl_reset_n,
    input  logic                      hold,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
`ifdef WB_BYPASS_EN
    input  logic [ADDR_W-1:0]         byp_readRegA,
    input  logic [ADDR_W-1:0]         byp_readRegB,
    output logic                      byp_hitA,
    output logic                      byp_hitB,
    output logic [DATA_W-1:0]         byp_dataA,
    output logic [DATA_W-1:0]         byp_dataB,
`endif
    output logic                      ctrl_writeEnable,
    output logic [ADDR_W-1:0]         ctrl_writeReg,
    output logic [DATA_W-1:0]         data_writeReg,
    output logic [DROP_W-1:0]         drop_count
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   rr_ptr;
    logic               handshake;
    logic [ADDR_W-1:0]  sel_reg;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_is_zero;

    assign eligible = req_valid & {NUM_REQ{~hold}};

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (idx)
    );

    // Ready is masked during reset so no source sees a handshake the stage will discard.
    assign req_ready   = ctrl_reset_n ? grant : '0;
    assign handshake   = |(req_valid & req_ready);
    assign sel_reg     = req_reg[idx*ADDR_W +: ADDR_W];
    assign sel_data    = req_data[idx*DATA_W +: DATA_W];
    assign sel_is_zero = (sel_reg == ADDR_W'(REG_ZERO));

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            rr_ptr           <= '0;
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
            drop_count       <= '0;
        end else if (handshake) begin
            ctrl_writeEnable <= !sel_is_zero;
            ctrl_writeReg    <= sel_reg;
            data_writeReg    <= sel_data;
            rr_ptr           <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            if (sel_is_zero) begin
                drop_count <= sat_inc(drop_count);
            end
        end else begin
            ctrl_writeEnable <= 1'b0;
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_hitA  = ctrl_writeEnable & (ctrl_writeReg == byp_readRegA);
    assign byp_hitB  = ctrl_writeEnable & (ctrl_writeReg == byp_readRegB);
    assign byp_dataA = byp_hitA ? data_writeReg : '0;
    assign byp_dataB = byp_hitB ? data_writeReg : '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vectors plus a per-cycle reference model.
// Bypass checks are included when WB_BYPASS_EN is defined.
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clock = 1'b0;
    logic            ctrl_reset_n;
    logic            hold;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_reg;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            ctrl_writeEnable;
    logic [AW-1:0]   ctrl_writeReg;
    logic [DW-1:0]   data_writeReg;
    logic [7:0]      drop_count;
`ifdef WB_BYPASS_EN
    logic [AW-1:0]   byp_readRegA, byp_readRegB;
    logic            byp_hitA, byp_hitB;
    logic [DW-1:0]   byp_dataA, byp_dataB;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .hold             (hold),
        .req_valid        (req_valid),
        .req_reg          (req_reg),
        .req_data         (req_data),
        .req_ready        (req_ready),
`ifdef WB_BYPASS_EN
        .byp_readRegA     (byp_readRegA),
        .byp_readRegB     (byp_readRegB),
        .byp_hitA         (byp_hitA),
        .byp_hitB         (byp_hitB),
        .byp_dataA        (byp_dataA),
        .byp_dataB        (byp_dataB),
`endif
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .drop_count       (drop_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the pointer is the requester with top priority; the winner is the
    // valid requester at the smallest cyclic distance from it.
    int          m_ptr  = 0;
    bit          m_we   = 0;
    logic [4:0]  m_reg  = '0;
    logic [31:0] m_data = '0;
    int          m_drop = 0;

    always @(negedge clock) begin
        int best, bestd, d;
        logic [N-1:0] exp_ready;
        logic [4:0] r;
        if (!ctrl_reset_n) begin
            m_ptr = 0; m_we = 0; m_reg = '0; m_data = '0; m_drop = 0;
        end
        check("m_we",   32'(ctrl_writeEnable), 32'(m_we));
        check("m_reg",  32'(ctrl_writeReg),    32'(m_reg));
        check("m_data", data_writeReg,         m_data);
        check("m_drop", 32'(drop_count),       32'(m_drop));
`ifdef WB_BYPASS_EN
        check("m_hitA",  32'(byp_hitA), 32'(m_we && m_reg == byp_readRegA));
        check("m_hitB",  32'(byp_hitB), 32'(m_we && m_reg == byp_readRegB));
        check("m_dataA", byp_dataA, (m_we && m_reg == byp_readRegA) ? m_data : 32'h0);
        check("m_dataB", byp_dataB, (m_we && m_reg == byp_readRegB) ? m_data : 32'h0);
`endif
        best = -1;
        bestd = N;
        if (ctrl_reset_n && !hold) begin
            for (int i = 0; i < N; i++) begin
                d = (i - m_ptr + N) % N;
                if (req_valid[i] && d < bestd) begin
                    bestd = d;
                    best = i;
                end
            end
        end
        exp_ready = '0;
        if (best >= 0) exp_ready[best] = 1'b1;
        check("m_ready", 32'(req_ready), 32'(exp_ready));
        // Advance the model to the state the coming posedge must produce.
        if (ctrl_reset_n) begin
            if (best >= 0) begin
                r = req_reg[best*AW +: AW];
                m_we   = (r != 0);
                m_reg  = r;
                m_data = req_data[best*DW +: DW];
                if (r == 0 && m_drop < 255) m_drop++;
                m_ptr = (best + 1) % N;
            end else begin
                m_we = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] r, input logic [31:0] d);
        req_valid[i] = v;
        req_reg[i*AW +: AW] = r;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        ctrl_reset_n = 1'b0;
        hold = 1'b0;
        req_valid = '0;
        req_reg = '0;
        req_data = '0;
`ifdef WB_BYPASS_EN
        byp_readRegA = '0;
        byp_readRegB = '0;
`endif
        set_req(0, 1'b1, 5'd1, 32'h1);
        tick;
        tick;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_we",    32'(ctrl_writeEnable), 32'h0);
        check("rst_reg",   32'(ctrl_writeReg), 32'h0);
        check("rst_data",  data_writeReg, 32'h0);
        check("rst_drop",  32'(drop_count), 32'h0);
        req_valid = '0;
        ctrl_reset_n = 1'b1;

        // Reset arriving right after a handshake discards the write in flight.
        set_req(1, 1'b1, 5'd3, 32'h55);
        tick;
        check("pre_we",   32'(ctrl_writeEnable), 32'h1);
        check("pre_reg",  32'(ctrl_writeReg), 32'h3);
        check("pre_data", data_writeReg, 32'h55);
        req_valid[1] = 1'b0;
        set_req(0, 1'b1, 5'd7, 32'hDEADBEEF);
        ctrl_reset_n = 1'b0;
        #1;
        check("midrst_we",    32'(ctrl_writeEnable), 32'h0);
        check("midrst_reg",   32'(ctrl_writeReg), 32'h0);
        check("midrst_data",  data_writeReg, 32'h0);
        check("midrst_ready", 32'(req_ready), 32'h0);
        tick;
        ctrl_reset_n = 1'b1;
        tick;
        check("first_we",   32'(ctrl_writeEnable), 32'h1);
        check("first_reg",  32'(ctrl_writeReg), 32'h7);
        check("first_data", data_writeReg, 32'hDEADBEEF);
        req_valid = '0;

        // Fairness: park the pointer at 0 via a lone req2 grant, then all valid for 9 cycles.
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 5'(10 + i), 32'h100 + 32'(i));
        req_valid[2] = 1'b1;
        tick;
        req_valid = '1;
        for (int k = 0; k < 9; k++) begin
            #1;
            check("fair_order", 32'(req_ready), 32'(1 << (k % 3)));
            tick;
        end
        check("fair_last_reg",  32'(ctrl_writeReg), 32'd12);
        check("fair_last_data", data_writeReg, 32'h102);
        req_valid = '0;

        // Writes to r0 are accepted but dropped; counter saturates.
        set_req(1, 1'b1, 5'd0, 32'h1234);
        #1;
        check("r0_ready",  32'(req_ready), 32'b010);
        check("r0_drop0",  32'(drop_count), 32'd0);
        tick;
        check("r0_we",     32'(ctrl_writeEnable), 32'h0);
        check("r0_drop1",  32'(drop_count), 32'd1);
        repeat (300) tick;
        check("r0_sat",    32'(drop_count), 32'd255);
        req_valid = '0;

        // hold: output drains, pointer frozen at 1, grant resumes there.
        set_req(0, 1'b1, 5'd4, 32'h44);
        tick;
        set_req(1, 1'b1, 5'd11, 32'h101);
        set_req(2, 1'b1, 5'd12, 32'h102);
        hold = 1'b1;
        #1;
        check("hold_we_first", 32'(ctrl_writeEnable), 32'h1);
        for (int h = 0; h < 3; h++) begin
            check("hold_ready", 32'(req_ready), 32'h0);
            tick;
            check("hold_we", 32'(ctrl_writeEnable), 32'h0);
        end
        hold = 1'b0;
        #1;
        check("hold_resume", 32'(req_ready), 32'b010);
        tick;
        req_valid = '0;

        // Sparse requests.
        req_valid[2] = 1'b1;
        #1;
        check("sparse_a", 32'(req_ready), 32'b100);
        tick;
        #1;
        check("sparse_b", 32'(req_ready), 32'b100);
        tick;
        req_valid[0] = 1'b1;
        #1;
        check("sparse_c", 32'(req_ready), 32'b001);
        tick;
        req_valid = '0;

        // Same destination from two requesters: grant order decides, last wins.
        set_req(1, 1'b1, 5'd9, 32'h11);
        set_req(0, 1'b1, 5'd9, 32'h22);
        tick;
        check("same_first", data_writeReg, 32'h11);
        req_valid[1] = 1'b0;
        tick;
        check("same_last_reg",  32'(ctrl_writeReg), 32'd9);
        check("same_last_data", data_writeReg, 32'h22);
        req_valid = '0;

`ifdef WB_BYPASS_EN
        set_req(0, 1'b1, 5'd5, 32'hA5A5A5A5);
        tick;
        req_valid = '0;
        byp_readRegA = 5'd5;
        byp_readRegB = 5'd6;
        #1;
        check("byp_hitA",  32'(byp_hitA), 32'h1);
        check("byp_dataA", byp_dataA, 32'hA5A5A5A5);
        check("byp_hitB",  32'(byp_hitB), 32'h0);
        check("byp_dataB", byp_dataB, 32'h0);
`endif

        repeat (3) tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
